peres_sweep_checker: RTL and testbench
======================================

# peres_sweep_checker

Sequential stimulus-and-check stage placed directly in front of a `peres_gate` instance.
- Drives all eight `{A,B,C}` input vectors into the gate in order.
- Samples the gate's `{P,Q,R}` response and compares it against the golden Peres function: P=A, Q=A^B, R=(A&B)^C.
- Confirms the gate is reversible, meaning all eight output codes are distinct.
- Reports pass/fail, error count and the first failing vector.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before it is checked. Minimum 1; 0 fails an elaboration-time assertion.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  begin a sweep. Accepted only in IDLE or DONE.
- `A`, `B`, `C`  out  1 each  stimulus to `peres_gate`.
- `P`, `Q`, `R`  in  1 each  response from `peres_gate`.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is entered.
- `done`  out  1  single-cycle pulse on entry to DONE.
- `pass`  out  1  valid while in DONE. Equals (`err_count`==0) && (`seen_mask`==8'hFF).
- `err_count`  out  4  number of mismatching vectors, range 0..8.
- `first_err_vec`  out  3  index of the first mismatching vector.
- `first_err_valid`  out  1  `first_err_vec` holds a valid index.
- `seen_mask`  out  8  bit k set when output code k={P,Q,R} has been observed.

## Operation
States: IDLE, DRIVE, CHECK, DONE.

- **IDLE**: waits for `start`. On `start`:
  - `vec`=0, settle counter=0.
  - `err_count`, `seen_mask`, `first_err_valid` cleared.
  - Go to DRIVE.
- **DRIVE**:
  - `{A,B,C}` = `vec`, registered.
  - Counter increments each cycle.
  - After `SETTLE_CYCLES` cycles in DRIVE, go to CHECK.
- **CHECK** (one cycle): compare `{P,Q,R}` against the golden function of `vec`.
  - Mismatch: `err_count`+1. If `first_err_valid`=0, latch `first_err_vec`=`vec` and set `first_err_valid`.
  - Always set `seen_mask[{P,Q,R}]`.
  - If `vec`==7, go to DONE. Otherwise `vec`+1, clear counter, go to DRIVE.
- **DONE**:
  - `done` pulses on the entry cycle.
  - `pass`, `err_count`, `first_err_*` and `seen_mask` hold until the next `start` or `rst`.
  - `start` in DONE restarts the sweep exactly as from IDLE.

Boundary conditions:
- `start` while `busy` is ignored and the sweep continues.
- `vec` never wraps: the 8th CHECK always exits to DONE.
- `err_count` maximum is 8, so it has no overflow.
- `{A,B,C}` hold the last vector (3'b111) in DONE.
- `seen_mask` is indexed by the response regardless of correctness.

## Timing
- Reset values, applied on the first `clk` edge with `rst`=1: state IDLE; `A`=`B`=`C`=0; `busy`=0; `done`=0; `pass`=0; `err_count`=0; `first_err_vec`=0; `first_err_valid`=0; `seen_mask`=0.
- `rst` mid-sweep aborts immediately to reset values. There is no `done` pulse.
- `start` sampled high at edge t means:
  - `busy`=1 and `{A,B,C}`=000 from t+1.
  - Each vector occupies `SETTLE_CYCLES`+1 cycles.
  - `done` is high in cycle t+1+8·(`SETTLE_CYCLES`+1). This is cycle t+25 for the default.
- `{P,Q,R}` are sampled at the clock edge ending the CHECK cycle, so the gate has at least `SETTLE_CYCLES` full cycles of stable input.
- `busy` falls in the same cycle `done` rises.

## Structure
- Shared package `peres_pkg`:
  - `state_t` enum (IDLE, DRIVE, CHECK, DONE).
  - `localparam NUM_VECTORS = 8`.
  - Function `peres_ref(logic [2:0] abc)` returning `logic [2:0] pqr`. Reused by testbenches.
- No sub-module inside the checker. `peres_gate` is instantiated alongside it and wired A/B/C→ and ←P/Q/R at the level above.

## Test plan
- Real `peres_gate`, default parameter, pulse `start` -> `done` 25 cycles later; `pass`=1, `err_count`=0, `first_err_valid`=0, `seen_mask`=8'hFF.
- Faulty gate with Q stuck at 0 -> `err_count`=4 (vectors 2–5), `first_err_vec`=2, `seen_mask`≠8'hFF, `pass`=0.
- Toffoli gate substituted (P=A, Q=B, R=AB^C) -> `err_count`=4 (vectors 4–7), `first_err_vec`=4, `seen_mask`=8'hFF, `pass`=0.
- `rst` asserted during vector 3 -> next cycle all outputs equal reset values, no `done`. A new `start` then completes with `pass`=1.
- `start` re-pulsed while `busy`, then again in DONE:
  - The mid-sweep pulse is ignored; `done` still arrives at t+25.
  - The DONE pulse restarts the sweep: `busy`=1 and `err_count` cleared on the next cycle.
- `SETTLE_CYCLES`=1 -> `done` at t+17. `{A,B,C}` checked to step 0..7, each held 2 cycles.

Source files
------------

// File: rtl/peres_pkg.sv
// Shared types and the golden Peres reference used by the sweep checker and its benches.
package peres_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam int NUM_VECTORS = 8;

    // P=A, Q=A^B, R=(A&B)^C with abc = {A,B,C}
    function automatic logic [2:0] peres_ref(logic [2:0] abc);
        return {abc[2], abc[2] ^ abc[1], (abc[2] & abc[1]) ^ abc[0]};
    endfunction

endpackage

// File: rtl/peres_sweep_checker_if.sv
// Stimulus/response bus between the sweep checker and the gate under test.
interface peres_sweep_checker_if;
    logic A, B, C;
    logic P, Q, R;

    modport master (output A, B, C, input P, Q, R);
    modport slave  (input A, B, C, output P, Q, R);
endinterface

// File: rtl/peres_sweep_checker.sv
// Walks all eight {A,B,C} codes through a Peres gate, checks each {P,Q,R} against
// the golden function and tracks which output codes appeared (reversibility).
module peres_sweep_checker
    import peres_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    peres_sweep_checker_if.master gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [3:0]           err_count,
    output logic [2:0]           first_err_vec,
    output logic                 first_err_valid,
    output logic [7:0]           seen_mask
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("peres_sweep_checker: SETTLE_CYCLES must be at least 1");
    end

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    VEC_LAST = 3'(NUM_VECTORS - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0]    vec;
    logic [2:0]    pqr;
    logic          mismatch;

    assign pqr      = {gate.P, gate.Q, gate.R};
    assign mismatch = (pqr != peres_ref(vec));

    // vec is itself a register, so the stimulus is glitch-free and holds 3'b111 in DONE
    assign gate.A = vec[2];
    assign gate.B = vec[1];
    assign gate.C = vec[0];

    assign pass = (state == DONE) && (err_count == 4'd0) && (seen_mask == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = DRIVE;
            DRIVE:      if (cnt == CNT_LAST) next_state = CHECK;
            CHECK:      next_state = (vec == VEC_LAST) ? DONE : DRIVE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            seen_mask       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt             <= '0;
                        vec             <= '0;
                        busy            <= 1'b1;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        seen_mask       <= '0;
                    end
                end
                DRIVE: cnt <= cnt + 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 4'd1;
                        if (!first_err_valid) begin
                            first_err_vec   <= vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    // Indexed by the observed response, right or wrong
                    seen_mask[pqr] <= 1'b1;
                    if (vec == VEC_LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        vec <= vec + 3'd1;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peres_sweep_checker.sv
// Directed bench: behavioural gate (real / Q stuck-at-0 / Toffoli) driving two checkers.
module tb_peres_sweep_checker;
    import peres_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic [1:0] mode = 2'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    peres_sweep_checker_if g0 ();
    peres_sweep_checker_if g1 ();

    logic busy0, done0, pass0, fevv0;
    logic [3:0] err0;
    logic [2:0] fev0;
    logic [7:0] seen0;
    logic busy1, done1, pass1, fevv1;
    logic [3:0] err1;
    logic [2:0] fev1;
    logic [7:0] seen1;

    peres_sweep_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_vec(fev0), .first_err_valid(fevv0), .seen_mask(seen0)
    );

    peres_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_vec(fev1), .first_err_valid(fevv1), .seen_mask(seen1)
    );

    // Gate models: 0 = Peres, 1 = Peres with Q stuck at 0, 2 = Toffoli
    logic [2:0] abc0, abc1, pqr0, pqr1;
    assign abc0 = {g0.A, g0.B, g0.C};
    assign abc1 = {g1.A, g1.B, g1.C};
    always_comb begin
        pqr0 = peres_ref(abc0);
        case (mode)
            2'd1:    pqr0 = {abc0[2], 1'b0, (abc0[2] & abc0[1]) ^ abc0[0]};
            2'd2:    pqr0 = {abc0[2], abc0[1], (abc0[2] & abc0[1]) ^ abc0[0]};
            default: ;
        endcase
    end
    assign pqr1 = peres_ref(abc1);
    assign g0.P = pqr0[2];
    assign g0.Q = pqr0[1];
    assign g0.R = pqr0[0];
    assign g1.P = pqr1[2];
    assign g1.Q = pqr1[1];
    assign g1.R = pqr1[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start0 and count cycles until done0 (cycle 1 is the one after the start edge)
    task automatic sweep0(output int n);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1;
        while (done0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_abc"},  32'(abc0),  32'h0);
        chk({tag, "_busy"}, 32'(busy0), 32'h0);
        chk({tag, "_done"}, 32'(done0), 32'h0);
        chk({tag, "_pass"}, 32'(pass0), 32'h0);
        chk({tag, "_err"},  32'(err0),  32'h0);
        chk({tag, "_fev"},  32'(fev0),  32'h0);
        chk({tag, "_fevv"}, 32'(fevv0), 32'h0);
        chk({tag, "_seen"}, 32'(seen0), 32'h0);
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        chk_reset0("rst");
        chk("rst1_busy", 32'(busy1), 32'h0);
        rst = 1'b0;
        tick();

        // Real gate, default settle
        mode = 2'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("t1_busy_rise", 32'(busy0), 32'h1);
        chk("t1_abc0", 32'(abc0), 32'h0);
        n = 1;
        while (done0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t1_latency", 32'(n), 32'd25);
        chk("t1_busy_fall", 32'(busy0), 32'h0);
        chk("t1_pass", 32'(pass0), 32'h1);
        chk("t1_err", 32'(err0), 32'h0);
        chk("t1_fevv", 32'(fevv0), 32'h0);
        chk("t1_seen", 32'(seen0), 32'hFF);
        chk("t1_abc_hold", 32'(abc0), 32'h7);
        tick();
        chk("t1_done_pulse", 32'(done0), 32'h0);
        chk("t1_pass_hold", 32'(pass0), 32'h1);

        // Q stuck at 0: vectors 2..5 fail, codes {0,1,4,5} seen
        mode = 2'd1;
        sweep0(n);
        chk("t2_latency", 32'(n), 32'd25);
        chk("t2_err", 32'(err0), 32'd4);
        chk("t2_fev", 32'(fev0), 32'd2);
        chk("t2_fevv", 32'(fevv0), 32'h1);
        chk("t2_seen", 32'(seen0), 32'h33);
        chk("t2_pass", 32'(pass0), 32'h0);

        // Toffoli gate, with a start re-pulse mid-sweep that must be ignored
        mode = 2'd2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1;
        repeat (4) begin tick(); n++; end
        start0 = 1'b1;
        tick();
        n++;
        start0 = 1'b0;
        chk("t3_busy_mid", 32'(busy0), 32'h1);
        while (done0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t3_latency", 32'(n), 32'd25);
        chk("t3_err", 32'(err0), 32'd4);
        chk("t3_fev", 32'(fev0), 32'd4);
        chk("t3_seen", 32'(seen0), 32'hFF);
        chk("t3_pass", 32'(pass0), 32'h0);

        // Restart from DONE with the real gate
        mode = 2'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("t4_busy", 32'(busy0), 32'h1);
        chk("t4_err_clr", 32'(err0), 32'h0);
        chk("t4_fevv_clr", 32'(fevv0), 32'h0);
        chk("t4_abc", 32'(abc0), 32'h0);
        chk("t4_pass", 32'(pass0), 32'h0);
        n = 1;
        while (done0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_latency", 32'(n), 32'd25);
        chk("t4_pass_end", 32'(pass0), 32'h1);

        // Reset during vector 3 aborts without a done pulse
        mode = 2'd1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (10) tick();
        chk("t5_abc_vec3", 32'(abc0), 32'h3);
        chk("t5_err_mid", 32'(err0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset0("t5");
        repeat (20) tick();
        chk("t5_no_done", 32'(done0), 32'h0);
        chk("t5_idle_busy", 32'(busy0), 32'h0);
        mode = 2'd0;
        sweep0(n);
        chk("t5_latency", 32'(n), 32'd25);
        chk("t5_pass", 32'(pass0), 32'h1);

        // SETTLE_CYCLES=1: each vector held two cycles, done at t+17
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < 2; h++) begin
                chk($sformatf("t6_abc_%0d_%0d", k, h), 32'(abc1), 32'(k));
                chk($sformatf("t6_nodone_%0d_%0d", k, h), 32'(done1), 32'h0);
                tick();
            end
        end
        chk("t6_done", 32'(done1), 32'h1);
        chk("t6_pass", 32'(pass1), 32'h1);
        chk("t6_seen", 32'(seen1), 32'hFF);
        chk("t6_err", 32'(err1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
